// File: rtl/spi_usb_pkg.sv
// Shared types and MAX3421E register map for the SPI USB responder.
package spi_usb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} spi_state_t;

  localparam int CMD_DIR_BIT  = 1;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;

  localparam logic [4:0] RCVFIFO = 5'd1;
  localparam logic [4:0] SNDFIFO = 5'd2;
  localparam logic [4:0] SUDFIFO = 5'd4;
  localparam logic [4:0] RCVBC   = 5'd6;
  localparam logic [4:0] SNDBC   = 5'd7;
  localparam logic [4:0] PINCTL  = 5'd17;
  localparam logic [4:0] REVISION = 5'd18;
  localparam logic [4:0] HIRQ    = 5'd25;
  localparam logic [4:0] MODE    = 5'd27;
  localparam logic [4:0] HXFR    = 5'd30;
  localparam logic [4:0] HRSL    = 5'd31;
endpackage

// File: rtl/spi_usb_responder_if.sv
// SPI pin bundle between the spi0 master and the responder.
interface spi_usb_responder_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic MISO_oe;

  modport master (output SS_n, SCLK, MOSI, input MISO, MISO_oe);
  modport slave  (input SS_n, SCLK, MOSI, output MISO, MISO_oe);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word peek; a push on a full FIFO only lands when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/spi_usb_responder.sv
// SPI mode-0 responder emulating the MAX3421E command/register protocol for hardware loopback.
module spi_usb_responder import spi_usb_pkg::*; #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [4:0] FIFO_ADDR   = RCVFIFO,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  spi_usb_responder_if.slave            spi,
  input  logic [7:0]                    status_in,
  input  logic                          fifo_push,
  input  logic [7:0]                    fifo_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          reg_wr,
  output logic [4:0]                    reg_wr_addr,
  output logic [7:0]                    reg_wr_data
);
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss, sclk, mosi, ss_d, sclk_d;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  // Synchronizers are not reset so a reset with SS_n held low does not fake an edge.
  always_ff @(posedge Clk) begin
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   spi.SS_n};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
    ss_d      <= ss;
    sclk_d    <= sclk;
  end

  assign ss        = ss_sync[SYNC_STAGES-1];
  assign sclk      = sclk_sync[SYNC_STAGES-1];
  assign mosi      = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss;
  assign ss_rise   = ~ss_d & ss;
  assign sclk_rise = ~sclk_d & sclk;
  assign sclk_fall = sclk_d & ~sclk;

  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out, rx_byte, rd_byte, fifo_head;
  logic [4:0] addr_q;
  logic       miso_q, oe_q, pop_armed, fifo_empty, is_fifo, byte_done;
  logic       active, shift_rise, load_rd, shift_fall, cap_cmd, do_write, fifo_pop;
  logic [7:0] regs [32];

  assign rx_byte   = {shift_in, mosi};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign is_fifo   = (addr_q == FIFO_ADDR);
  assign rd_byte   = is_fifo ? (fifo_empty ? 8'h00 : fifo_head) : regs[addr_q];

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_fall)      state_d = CMD;
    else if (ss_rise) state_d = IDLE;
    else if (state_q == CMD && byte_done)
      state_d = rx_byte[CMD_DIR_BIT] ? WR : RD;
  end

  always_comb begin
    active     = !ss_fall && !ss_rise && (state_q != IDLE);
    shift_rise = active & sclk_rise;
    load_rd    = active & sclk_fall & (state_q == RD) & (bit_cnt == 3'd0);
    shift_fall = active & sclk_fall & ~load_rd;
    cap_cmd    = active & byte_done & (state_q == CMD);
    do_write   = active & byte_done & (state_q == WR);
    fifo_pop   = active & byte_done & (state_q == RD) & pop_armed;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr_q      <= '0;
      pop_armed   <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      reg_wr <= 1'b0;
      if (ss_fall) begin
        shift_out <= status_in;
        miso_q    <= status_in[7];
        oe_q      <= 1'b1;
        bit_cnt   <= '0;
        pop_armed <= 1'b0;
      end else if (load_rd) begin
        // Pop eligibility is frozen at load so a later push cannot cause a pop of unsent data.
        shift_out <= rd_byte;
        miso_q    <= rd_byte[7];
        pop_armed <= is_fifo & ~fifo_empty;
      end else if (shift_fall) begin
        shift_out <= {shift_out[6:0], 1'b0};
        miso_q    <= shift_out[6];
      end
      if (ss_rise) oe_q <= 1'b0;
      if (shift_rise) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (cap_cmd) addr_q <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
      if (do_write) begin
        if (!is_fifo) regs[addr_q] <= rx_byte;
        reg_wr      <= 1'b1;
        reg_wr_addr <= addr_q;
        reg_wr_data <= rx_byte;
      end
    end
  end

  assign spi.MISO    = miso_q;
  assign spi.MISO_oe = oe_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_data),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_spi_usb_responder.sv
// Bench for spi_usb_responder: directed vector table, hand sequences and a queue/array reference model.
module tb_spi_usb_responder;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] status_in;
  logic       fifo_push;
  logic [7:0] fifo_data;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic       reg_wr;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;

  spi_usb_responder_if spi();

  spi_usb_responder #(.FIFO_DEPTH(DEPTH), .FIFO_ADDR(5'd1), .SYNC_STAGES(2)) dut (
    .Clk(clk), .Reset_n(rst_n), .spi(spi), .status_in(status_in),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;

  always @(negedge clk) if (reg_wr === 1'b1) wr_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: register array plus a FIFO queue.
  logic [7:0] m_regs [32];
  logic [7:0] m_q [$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_q.delete();
  endtask

  task automatic model_xfer(input logic [7:0] st, input logic [7:0] cmd, input int n,
                            input logic [3:0][7:0] d, output logic [4:0][7:0] e, output int nwr);
    int a;
    a = int'(cmd[7:3]);
    e = '0;
    e[0] = st;
    nwr = 0;
    for (int i = 0; i < n; i++) begin
      if (cmd[1]) begin
        if (a != 1) m_regs[a] = d[i];
        nwr++;
      end else if (a == 1) begin
        if (m_q.size() > 0) e[i+1] = m_q.pop_front();
        else e[i+1] = 8'h00;
      end else begin
        e[i+1] = m_regs[a];
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    fifo_data = b;
    fifo_push = 1'b1;
    @(negedge clk);
    fifo_push = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(b);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit push_last,
                          output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      spi.MOSI = tx[7-k];
      repeat (5) @(negedge clk);
      rx[7-k] = spi.MISO;
      spi.SCLK = 1'b1;
      if (push_last && k == 7) begin
        fifo_data = 8'hEE;
        fifo_push = 1'b1;
      end
      repeat (5) @(negedge clk);
      spi.SCLK = 1'b0;
      fifo_push = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input int n, input logic [3:0][7:0] d,
                      input int last_bits, input bit push_last, output logic [4:0][7:0] r);
    logic [7:0] b;
    r = '0;
    spi.SS_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("oe_active", {31'b0, spi.MISO_oe}, 32'd1);
    spi_byte(cmd, 8, 1'b0, b);
    r[0] = b;
    for (int i = 0; i < n; i++) begin
      spi_byte(d[i], (i == n-1) ? last_bits : 8, push_last && (i == n-1), b);
      r[i+1] = b;
    end
    repeat (5) @(negedge clk);
    spi.SS_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("oe_idle", {31'b0, spi.MISO_oe}, 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]      st;
    logic [7:0]      cmd;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic [4:0][7:0] e;
    logic            rd;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [4:0][7:0] r, e;
    logic [3:0][7:0] d;
    int nwr, p0;
    logic [4:0] a;
    logic [7:0] cmd;
    int n;

    vt[0] = '{st:8'hA5, cmd:8'hC8, n:3'd1, d:32'h0,          e:{24'h0, 8'h00, 8'hA5},         rd:1'b1};
    vt[1] = '{st:8'h5A, cmd:8'h8A, n:3'd1, d:{24'h0, 8'h3C}, e:{24'h0, 8'h00, 8'h5A},         rd:1'b0};
    vt[2] = '{st:8'h00, cmd:8'h88, n:3'd1, d:32'h0,          e:{24'h0, 8'h3C, 8'h00},         rd:1'b1};
    vt[3] = '{st:8'hFF, cmd:8'h08, n:3'd2, d:32'h0,          e:{16'h0, 8'h00, 8'h00, 8'hFF},  rd:1'b1};

    spi.SS_n = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
    status_in = 8'h00; fifo_push = 1'b0; fifo_data = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_miso", {31'b0, spi.MISO}, 0);
    chk("rst_oe", {31'b0, spi.MISO_oe}, 0);
    chk("rst_count", {28'b0, fifo_count}, 0);
    chk("rst_full", {31'b0, fifo_full}, 0);
    chk("rst_reg_wr", {31'b0, reg_wr}, 0);
    chk("rst_wr_addr", {27'b0, reg_wr_addr}, 0);
    chk("rst_wr_data", {24'b0, reg_wr_data}, 0);

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      status_in = vt[v].st;
      model_xfer(vt[v].st, vt[v].cmd, int'(vt[v].n), vt[v].d, e, nwr);
      xfer(vt[v].cmd, int'(vt[v].n), vt[v].d, 8, 1'b0, r);
      chk($sformatf("vec%0d_status", v), {24'b0, r[0]}, {24'b0, vt[v].e[0]});
      if (vt[v].rd)
        for (int i = 1; i <= int'(vt[v].n); i++)
          chk($sformatf("vec%0d_byte%0d", v, i), {24'b0, r[i]}, {24'b0, vt[v].e[i]});
    end
    chk("wr_pulses", wr_pulses, 1);
    chk("wr_addr", {27'b0, reg_wr_addr}, 17);
    chk("wr_data", {24'b0, reg_wr_data}, 32'h3C);

    // FIFO drain past empty.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    chk("drain_count_pre", {28'b0, fifo_count}, 3);
    model_xfer(8'h00, 8'h08, 4, '0, e, nwr);
    xfer(8'h08, 4, '0, 8, 1'b0, r);
    chk("drain_b1", {24'b0, r[1]}, 32'h11);
    chk("drain_b2", {24'b0, r[2]}, 32'h22);
    chk("drain_b3", {24'b0, r[3]}, 32'h33);
    chk("drain_b4", {24'b0, r[4]}, 32'h00);
    chk("drain_count_post", {28'b0, fifo_count}, 0);

    // Overflow, then a push held across the popping SCLK rise.
    for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i));
    chk("ovf_count", {28'b0, fifo_count}, 8);
    chk("ovf_full", {31'b0, fifo_full}, 1);
    xfer(8'h08, 1, '0, 8, 1'b1, r);
    chk("simul_byte", {24'b0, r[1]}, 32'h40);
    chk("simul_count", {28'b0, fifo_count}, 8);
    void'(m_q.pop_front());
    m_q.push_back(8'hEE);
    model_xfer(8'h00, 8'h08, 4, '0, e, nwr);
    xfer(8'h08, 4, '0, 8, 1'b0, r);
    for (int i = 1; i <= 4; i++) chk($sformatf("simul_drainA%0d", i), {24'b0, r[i]}, 32'h40 + i);
    model_xfer(8'h00, 8'h08, 4, '0, e, nwr);
    xfer(8'h08, 4, '0, 8, 1'b0, r);
    for (int i = 1; i <= 3; i++) chk($sformatf("simul_drainB%0d", i), {24'b0, r[i]}, 32'h44 + i);
    chk("simul_tail", {24'b0, r[4]}, 32'hEE);
    chk("simul_empty", {28'b0, fifo_count}, 0);

    // Aborted write and aborted FIFO read.
    p0 = wr_pulses;
    xfer(8'h8A, 1, {24'h0, 8'h99}, 5, 1'b0, r);
    chk("abort_wr_pulses", wr_pulses, p0);
    xfer(8'h88, 1, '0, 8, 1'b0, r);
    chk("abort_wr_reg", {24'b0, r[1]}, 32'h3C);
    push_byte(8'hAB);
    xfer(8'h08, 1, '0, 5, 1'b0, r);
    chk("abort_rd_count", {28'b0, fifo_count}, 1);
    model_xfer(8'h00, 8'h08, 1, '0, e, nwr);
    xfer(8'h08, 1, '0, 8, 1'b0, r);
    chk("abort_rd_next", {24'b0, r[1]}, 32'hAB);

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) push_byte(8'($urandom));
      case ($urandom_range(0, 3))
        0: a = 5'd1;
        1: a = 5'd17;
        2: a = 5'd25;
        default: a = 5'($urandom);
      endcase
      cmd = {a, 1'($urandom), 1'($urandom), 1'($urandom)};
      n = int'($urandom_range(1, 3));
      d = 32'($urandom);
      status_in = 8'($urandom);
      p0 = wr_pulses;
      model_xfer(status_in, cmd, n, d, e, nwr);
      xfer(cmd, n, d, 8, 1'b0, r);
      chk($sformatf("rnd%0d_status", t), {24'b0, r[0]}, {24'b0, e[0]});
      if (!cmd[1])
        for (int i = 1; i <= n; i++)
          chk($sformatf("rnd%0d_byte%0d", t, i), {24'b0, r[i]}, {24'b0, e[i]});
      else begin
        chk($sformatf("rnd%0d_pulses", t), wr_pulses - p0, nwr);
        chk($sformatf("rnd%0d_wr_addr", t), {27'b0, reg_wr_addr}, {27'b0, a});
        chk($sformatf("rnd%0d_wr_data", t), {24'b0, reg_wr_data}, {24'b0, d[n-1]});
      end
      chk($sformatf("rnd%0d_count", t), {28'b0, fifo_count}, m_q.size());
    end

    // Reset in the middle of a read data byte.
    push_byte(8'h5E); push_byte(8'h6F);
    model_xfer(8'h00, 8'h1A, 1, {24'h0, 8'h55}, e, nwr);
    xfer(8'h1A, 1, {24'h0, 8'h55}, 8, 1'b0, r);
    spi.SS_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h18, 8, 1'b0, r[0]);
    spi_byte(8'h00, 3, 1'b0, r[1]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_miso", {31'b0, spi.MISO}, 0);
    chk("mid_rst_oe", {31'b0, spi.MISO_oe}, 0);
    chk("mid_rst_count", {28'b0, fifo_count}, 0);
    chk("mid_rst_full", {31'b0, fifo_full}, 0);
    chk("mid_rst_wr_addr", {27'b0, reg_wr_addr}, 0);
    chk("mid_rst_wr_data", {24'b0, reg_wr_data}, 0);
    model_reset();
    repeat (3) @(negedge clk);
    spi.SS_n = 1'b1;
    repeat (5) @(negedge clk);
    xfer(8'h18, 1, '0, 8, 1'b0, r);
    chk("mid_rst_reg3", {24'b0, r[1]}, 0);
    xfer(8'h88, 1, '0, 8, 1'b0, r);
    chk("mid_rst_reg17", {24'b0, r[1]}, 0);
    xfer(8'h08, 1, '0, 8, 1'b0, r);
    chk("mid_rst_fifo", {24'b0, r[1]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_usb_responder.md
Name: spi_usb_responder

Overview:
- Synthesizable SPI mode-0 responder that emulates the MAX3421E register-command protocol, i.e. the peripheral end of the spi0 master in lab62soc.
- Lets the Nios USB driver run in hardware loopback with the Arduino shield removed: the spi0 pins are routed to this block instead of ARDUINO_IO.
- Local-side ports let a test harness preload a receive FIFO, drive the status byte, and observe register writes.

Parameters:
- FIFO_DEPTH, 8, entries in the receive FIFO (power of 2, 2..64).
- FIFO_ADDR, 5'd1, register address whose reads pop the FIFO (RCVFIFO).
- SYNC_STAGES, 2, synchronizer flops on SS_n, SCLK and MOSI.

Ports:
- Clk  in  1  system clock, 50 MHz (MAX10_CLK1_50).
- Reset_n  in  1  synchronous active-low reset.
- SS_n  in  1  SPI slave select from spi0_SS_n, active low.
- SCLK  in  1  SPI clock from spi0_SCLK; must be at most Clk/8.
- MOSI  in  1  SPI data from master.
- MISO  out  1  SPI data to master.
- MISO_oe  out  1  MISO output enable; top level tri-states MISO when low.
- status_in  in  8  status byte (HIRQ image) shifted out during the command byte.
- fifo_push  in  1  push fifo_data into the receive FIFO.
- fifo_data  in  8  FIFO write data.
- fifo_full  out  1  FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- reg_wr  out  1  one-Clk pulse per completed SPI write data byte.
- reg_wr_addr  out  5  address of that write.
- reg_wr_data  out  8  data of that write.

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - MISO=0, MISO_oe=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0.
  - FIFO emptied: fifo_count=0, fifo_full=0.
  - 32x8 register file cleared; FSM to IDLE.
  - Applies mid-transaction too; the partial transfer is discarded.
- Edge detection: inputs pass through SYNC_STAGES flops. SCLK rise/fall and SS_n fall/rise are one-Clk strobes from the last two synchronized samples.
- Bit order and edges: MSB first. MOSI is sampled on SCLK rise; MISO changes on SCLK fall or SS_n fall.
- FSM states: IDLE, CMD, RD, WR.
  - IDLE, SS_n fall: load shift-out reg with status_in, MISO_oe=1, MISO=bit7, go CMD. MISO is valid SYNC_STAGES+1 Clk after the SS_n pin falls.
  - CMD, 8th SCLK rise: capture cmd byte; addr=cmd[7:3], dir=cmd[1] (1=write); cmd[0] (ACKSTAT) ignored. Go WR if dir=1, else RD.
  - RD, each SCLK fall at a byte boundary: load shift-out with the read byte and drive its bit7.
    - Read byte = reg[addr], or FIFO head (peek) if addr==FIFO_ADDR.
    - An empty FIFO reads 0x00.
  - RD, 8th SCLK rise of a data byte: if addr==FIFO_ADDR and FIFO was non-empty at load, pop one entry. No address auto-increment: repeated bytes re-read the same addr / successive FIFO entries.
  - WR, 8th SCLK rise of each data byte: reg[addr]<=byte (skipped when addr==FIFO_ADDR). reg_wr pulses one Clk later with addr/data; reg_wr_addr/data hold until the next write.
  - Any state, SS_n rise: go IDLE, MISO_oe=0. A partial byte (<8 bits) is discarded: no write, no pop, no reg_wr.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary; cleared on SS_n fall.
- FIFO:
  - Push while full is ignored.
  - Push and pop in the same Clk: count unchanged, data ordering preserved.
  - fifo_full = (count==FIFO_DEPTH).
- SS_n fall while not IDLE (glitch without a rise) restarts at CMD.

Decomposition:
- Package spi_usb_pkg:
  - typedef spi_state_t {IDLE,CMD,RD,WR}.
  - localparams CMD_DIR_BIT=1, CMD_ADDR_MSB=7, CMD_ADDR_LSB=3.
  - MAX3421E register address constants (RCVFIFO=1, SNDFIFO=2, HIRQ=25, ...).
- Sub-module sync_fifo (parameterized width/depth, count/full/empty) holds the receive FIFO; synchronizers and FSM stay in the top module.

Test Plan:
- Status shift: status_in=8'hA5, SS_n low, SCLK=Clk/10, cmd 8'hC8 (reg25 read) -> MISO bits during cmd read back 0xA5; MISO_oe=1 only while SS_n low.
- Write then read: write reg 5'd17 with 8'h3C (cmd 8'h8A, data 3C) -> one reg_wr pulse, addr 17, data 3C. Then read (cmd 8'h88) -> 8'h3C.
- FIFO drain: push 11,22,33; read FIFO_ADDR for 4 data bytes in one transaction -> 11,22,33,00; fifo_count 3->0; no underflow.
- Overflow, simultaneous push/pop: push 9 bytes into depth 8 -> count 8, 9th dropped. Push during a pop-completing SCLK rise -> count unchanged.
- Abort: SS_n rises after 5 bits of a write data byte or FIFO read byte -> no reg_wr, no pop, FSM IDLE; the next transaction works normally.
- Reset mid-transfer: Reset_n low for 1 Clk during RD -> outputs zero, FIFO empty, regs read 00 afterwards.
